// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin packet arbiter for N_INP valid/ready streams.
// A granted input keeps the output for up to `weight` whole packets; the
// grant is released early when the input goes idle between packets.
module stream_wrr_arbiter #(
    parameter type         DATA_T  = logic,
    parameter int unsigned N_INP   = 2,
    parameter int unsigned W_WIDTH = 4,
    localparam int unsigned IDX_W  = $clog2(N_INP)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic [N_INP*W_WIDTH-1:0]   weight_i,
    input  DATA_T                      inp_data_i [N_INP],
    input  logic [N_INP-1:0]           inp_valid_i,
    input  logic [N_INP-1:0]           inp_last_i,
    output logic [N_INP-1:0]           inp_ready_o,
    output DATA_T                      oup_data_o,
    output logic                       oup_valid_o,
    output logic                       oup_last_o,
    input  logic                       oup_ready_i,
    output logic [IDX_W-1:0]           idx_o
);

    if (N_INP < 2) begin : g_bad_n_inp
        $error("stream_wrr_arbiter: N_INP must be at least 2");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   rr_q;
    logic [W_WIDTH-1:0] cred_q;
    logic               mid_q;

    logic [IDX_W-1:0]   win;
    logic               found;
    logic [W_WIDTH-1:0] win_weight;
    logic [IDX_W-1:0]   rr_inc;
    logic               locked;
    logic               hs;

    // Pick the first valid input at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned cand;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N_INP; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= N_INP) begin
                cand = cand - N_INP;
            end
            if (!found && inp_valid_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
        win_weight = weight_i[win*W_WIDTH +: W_WIDTH];
        rr_inc     = (32'(gnt_q) == N_INP - 1) ? '0 : gnt_q + IDX_W'(1);
    end

    // Mirror the granted input onto the output while locked and not clearing.
    always_comb begin
        locked      = (state_q == LOCKED) && !clr_i;
        oup_data_o  = inp_data_i[gnt_q];
        oup_valid_o = locked && inp_valid_i[gnt_q];
        oup_last_o  = locked && inp_last_i[gnt_q];
        inp_ready_o = '0;
        if (locked) begin
            inp_ready_o[gnt_q] = oup_ready_i;
        end
        hs = oup_valid_o && oup_ready_i;
    end

    assign idx_o = gnt_q;

    // Grant FSM: packet credit accounting, in-packet tracking and release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cred_q  <= '0;
            mid_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cred_q  <= '0;
            mid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= LOCKED;
                        gnt_q   <= win;
                        cred_q  <= (win_weight == '0) ? W_WIDTH'(1) : win_weight;
                        mid_q   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (hs) begin
                        if (!oup_last_o) begin
                            mid_q <= 1'b1;
                        end else if (cred_q > W_WIDTH'(1)) begin
                            cred_q <= cred_q - W_WIDTH'(1);
                            mid_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            rr_q    <= rr_inc;
                            cred_q  <= '0;
                            mid_q   <= 1'b0;
                        end
                    end else if (!mid_q && !inp_valid_i[gnt_q]) begin
                        // Input idle between packets: give up remaining credit.
                        state_q <= IDLE;
                        rr_q    <= rr_inc;
                        cred_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Directed bench for stream_wrr_arbiter: a 4-input and a 3-input instance.
module tb_stream_wrr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr4, clr3;

    logic [15:0] w4;
    logic [7:0]  d4 [4];
    logic [3:0]  v4, l4, rdy4;
    logic [7:0]  od4;
    logic        ov4, ol4, or4;
    logic [1:0]  idx4;

    logic [11:0] w3;
    logic [7:0]  d3 [3];
    logic [2:0]  v3, l3, rdy3;
    logic [7:0]  od3;
    logic        ov3, ol3, or3;
    logic [1:0]  idx3;

    int n_vec = 0;
    int n_err = 0;

    int s2_ov  [12] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1};
    int s2_idx [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};

    stream_wrr_arbiter #(
        .DATA_T  (logic [7:0]),
        .N_INP   (4),
        .W_WIDTH (4)
    ) u_dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr4),
        .weight_i    (w4),
        .inp_data_i  (d4),
        .inp_valid_i (v4),
        .inp_last_i  (l4),
        .inp_ready_o (rdy4),
        .oup_data_o  (od4),
        .oup_valid_o (ov4),
        .oup_last_o  (ol4),
        .oup_ready_i (or4),
        .idx_o       (idx4)
    );

    stream_wrr_arbiter #(
        .DATA_T  (logic [7:0]),
        .N_INP   (3),
        .W_WIDTH (4)
    ) u_dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr3),
        .weight_i    (w3),
        .inp_data_i  (d3),
        .inp_valid_i (v3),
        .inp_last_i  (l3),
        .inp_ready_o (rdy3),
        .oup_data_o  (od3),
        .oup_valid_o (ov3),
        .oup_last_o  (ol3),
        .oup_ready_i (or3),
        .idx_o       (idx3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear4();
        clr4 = 1'b1;
        settle();
        chk("clr4_ov", 32'(ov4), 0);
        chk("clr4_rdy", 32'(rdy4), 0);
        step();
        clr4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        clr4 = 1'b0;
        clr3 = 1'b0;
        w4 = '0; v4 = '0; l4 = '0; or4 = 1'b0;
        w3 = '0; v3 = '0; l3 = '0; or3 = 1'b0;
        for (int k = 0; k < 4; k++) d4[k] = 8'hA0 + 8'(k);
        for (int k = 0; k < 3; k++) d3[k] = 8'hC0 + 8'(k);
        #3;
        chk("rst_ov4", 32'(ov4), 0);
        chk("rst_rdy4", 32'(rdy4), 0);
        chk("rst_idx4", 32'(idx4), 0);
        chk("rst_ov3", 32'(ov3), 0);
        step();
        step();
        rst = 1'b0;

        // Round-robin, all weights 1, 1-beat packets
        w4 = 16'h1111; v4 = 4'hF; l4 = 4'hF; or4 = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("rr_idle_ov", 32'(ov4), 0);
            chk("rr_idle_rdy", 32'(rdy4), 0);
            step();
            chk("rr_ov", 32'(ov4), 1);
            chk("rr_idx", 32'(idx4), 32'(k % 4));
            chk("rr_data", 32'(od4), 32'(8'hA0 + 8'(k % 4)));
            chk("rr_rdy", 32'(rdy4), 32'(1 << (k % 4)));
            step();
        end
        clear4();

        // Weights {3,1}: grants 0,0,0,1 repeating
        w4 = 16'h0013; v4 = 4'b0011; l4 = 4'hF; or4 = 1'b1;
        settle();
        for (int c = 0; c < 12; c++) begin
            chk("wt_ov", 32'(ov4), 32'(s2_ov[c]));
            chk("wt_idx", 32'(idx4), 32'(s2_idx[c]));
            step();
        end
        clear4();

        // Packet lock: 4-beat packet from input 0, ready toggling
        w4 = 16'h0011; v4 = 4'b0011; l4 = 4'b0010; d4[1] = 8'hB1; or4 = 1'b0;
        d4[0] = 8'h01;
        settle();
        chk("lock_idle_ov", 32'(ov4), 0);
        step();
        for (int b = 0; b < 4; b++) begin
            d4[0] = 8'h01 + 8'(b);
            l4[0] = (b == 3);
            or4 = 1'b0;
            settle();
            chk("lock_ov", 32'(ov4), 1);
            chk("lock_idx", 32'(idx4), 0);
            chk("lock_data", 32'(od4), 32'(8'h01 + 8'(b)));
            chk("lock_last", 32'(ol4), 32'(b == 3));
            chk("lock_rdy_lo", 32'(rdy4), 0);
            step();
            or4 = 1'b1;
            settle();
            chk("lock_data_stable", 32'(od4), 32'(8'h01 + 8'(b)));
            chk("lock_rdy_hi", 32'(rdy4), 32'h1);
            step();
        end
        v4[0] = 1'b0;
        settle();
        chk("lock_after_ov", 32'(ov4), 0);
        step();
        chk("lock_next_idx", 32'(idx4), 1);
        chk("lock_next_ov", 32'(ov4), 1);
        chk("lock_next_data", 32'(od4), 32'hB1);
        step();
        clear4();

        // Forfeit: weight 2 on input 2, valid drops after first packet
        w4 = 16'h0200; v4 = 4'b0100; l4 = 4'hF; or4 = 1'b1;
        settle();
        chk("ff_idle_ov", 32'(ov4), 0);
        step();
        chk("ff_ov", 32'(ov4), 1);
        chk("ff_idx", 32'(idx4), 2);
        step();
        v4 = 4'b0000;
        settle();
        chk("ff_drop_ov", 32'(ov4), 0);
        chk("ff_drop_idx", 32'(idx4), 2);
        step();
        v4 = 4'b1101;
        settle();
        chk("ff_idle_after_ov", 32'(ov4), 0);
        step();
        chk("ff_rr3_idx", 32'(idx4), 3);
        chk("ff_rr3_ov", 32'(ov4), 1);
        step();
        clear4();

        // Stall: valid drops mid-packet, grant holds
        w4 = 16'h0011; v4 = 4'b0011; l4 = 4'b0010; d4[0] = 8'h51; or4 = 1'b1;
        settle();
        chk("st_idle_ov", 32'(ov4), 0);
        step();
        chk("st_b0_ov", 32'(ov4), 1);
        chk("st_b0_data", 32'(od4), 32'h51);
        chk("st_b0_last", 32'(ol4), 0);
        step();
        v4[0] = 1'b0;
        settle();
        chk("st_hold_ov", 32'(ov4), 0);
        chk("st_hold_idx", 32'(idx4), 0);
        chk("st_hold_rdy", 32'(rdy4), 32'h1);
        step();
        chk("st_hold2_ov", 32'(ov4), 0);
        chk("st_hold2_idx", 32'(idx4), 0);
        step();
        v4[0] = 1'b1; d4[0] = 8'h52; l4[0] = 1'b1;
        settle();
        chk("st_b1_ov", 32'(ov4), 1);
        chk("st_b1_idx", 32'(idx4), 0);
        chk("st_b1_data", 32'(od4), 32'h52);
        chk("st_b1_last", 32'(ol4), 1);
        step();
        v4[0] = 1'b0;
        settle();
        chk("st_after_ov", 32'(ov4), 0);
        step();
        chk("st_next_idx", 32'(idx4), 1);
        chk("st_next_ov", 32'(ov4), 1);
        step();
        clear4();

        // Clear mid-packet
        w4 = 16'h1111; v4 = 4'b1010; l4 = 4'b0000; d4[1] = 8'h61; or4 = 1'b1;
        settle();
        chk("cm_idle_ov", 32'(ov4), 0);
        step();
        chk("cm_idx", 32'(idx4), 1);
        chk("cm_ov", 32'(ov4), 1);
        step();
        clr4 = 1'b1;
        settle();
        chk("cm_clr_ov", 32'(ov4), 0);
        chk("cm_clr_rdy", 32'(rdy4), 0);
        step();
        clr4 = 1'b0;
        or4 = 1'b0;
        settle();
        chk("cm_post_ov", 32'(ov4), 0);
        chk("cm_post_idx", 32'(idx4), 0);
        step();
        chk("cm_regrant_idx", 32'(idx4), 1);
        chk("cm_regrant_ov", 32'(ov4), 1);

        // Asynchronous reset between edges
        or4 = 1'b1;
        settle();
        chk("ar_pre_rdy", 32'(rdy4), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_ov", 32'(ov4), 0);
        chk("ar_rdy", 32'(rdy4), 0);
        chk("ar_idx", 32'(idx4), 0);
        step();
        step();
        rst = 1'b0;
        v4 = 4'hF; l4 = 4'hF;
        settle();
        chk("ar_idle_ov", 32'(ov4), 0);
        step();
        chk("ar_restart_idx", 32'(idx4), 0);
        chk("ar_restart_ov", 32'(ov4), 1);
        step();
        clear4();

        // N_INP=3: wrap and zero weight on input 2
        w3 = 12'h000; v3 = 3'b010; l3 = 3'b111; or3 = 1'b1;
        settle();
        chk("wz_idle_ov", 32'(ov3), 0);
        step();
        chk("wz_g1_ov", 32'(ov3), 1);
        chk("wz_g1_idx", 32'(idx3), 1);
        step();
        v3 = 3'b100;
        settle();
        chk("wz_idle2_ov", 32'(ov3), 0);
        step();
        chk("wz_g2_ov", 32'(ov3), 1);
        chk("wz_g2_idx", 32'(idx3), 2);
        chk("wz_g2_data", 32'(od3), 32'hC2);
        step();
        v3 = 3'b111;
        settle();
        chk("wz_one_pkt_ov", 32'(ov3), 0);
        chk("wz_hold_idx", 32'(idx3), 2);
        step();
        chk("wz_wrap_idx", 32'(idx3), 0);
        chk("wz_wrap_ov", 32'(ov3), 1);
        clr3 = 1'b1;
        settle();
        chk("wz_clr_ov", 32'(ov3), 0);
        chk("wz_clr_rdy", 32'(rdy3), 0);
        step();
        clr3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
